// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared writeback-stage widths, lane record, state enum and popcount helper
package cpu_defs;

  localparam int XLEN       = 32;
  localparam int REG_IDX_W  = 5;
  localparam int CSR_ADDR_W = 14;
  localparam int MAX_LANES  = 4;

  typedef enum logic {
    IDLE,
    DRAIN
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_IDX_W-1:0]  rd;
    logic                  wr_rd;
    logic [XLEN-1:0]       rd_data;
    logic                  wr_csr;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [XLEN-1:0]       csr_data;
  } wb_lane_t;

  function automatic logic [2:0] popcount4(input logic [MAX_LANES-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/writeback_multi_if.sv
// rtl/writeback_multi_if.sv - bundle-in / regfile+CSR-out bus of the multi-lane writeback stage
interface writeback_multi_if #(
  parameter int N_LANES    = 2,
  parameter int XLEN       = 32,
  parameter int REG_IDX_W  = 5,
  parameter int CSR_ADDR_W = 14
);

  logic                          next_rdy_in;
  logic                          rdy_in;
  logic [N_LANES-1:0]            in_valid;
  logic [N_LANES*REG_IDX_W-1:0]  in_rd;
  logic [N_LANES-1:0]            in_wr_rd;
  logic [N_LANES*XLEN-1:0]       in_rd_data;
  logic [N_LANES-1:0]            in_wr_csr;
  logic [N_LANES*CSR_ADDR_W-1:0] in_csr_addr;
  logic [N_LANES*XLEN-1:0]       in_csr_data;
  logic [N_LANES-1:0]            reg_we;
  logic [N_LANES*REG_IDX_W-1:0]  reg_idx;
  logic [N_LANES*XLEN-1:0]       reg_data;
  logic                          csr_we;
  logic [CSR_ADDR_W-1:0]         csr_addr;
  logic [XLEN-1:0]               csr_data;
  logic [63:0]                   instret;

  modport master (
    output next_rdy_in, in_valid, in_rd, in_wr_rd, in_rd_data,
           in_wr_csr, in_csr_addr, in_csr_data,
    input  rdy_in, reg_we, reg_idx, reg_data, csr_we, csr_addr, csr_data, instret
  );

  modport slave (
    input  next_rdy_in, in_valid, in_rd, in_wr_rd, in_rd_data,
           in_wr_csr, in_csr_addr, in_csr_data,
    output rdy_in, reg_we, reg_idx, reg_data, csr_we, csr_addr, csr_data, instret
  );

endinterface

// File: rtl/wb_csr_serializer.sv
// rtl/wb_csr_serializer.sv - drains a bundle's CSR writes one per fire cycle, oldest lane first
module wb_csr_serializer #(
  parameter int N_LANES = 2,
  parameter int SEL_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               fire,
  input  logic [N_LANES-1:0] load_mask,
  output logic               csr_we,
  output logic [SEL_W-1:0]   csr_sel,
  output logic               last
);
  import cpu_defs::*;

  wb_state_e            state;
  logic [N_LANES-1:0]   pend;
  logic [MAX_LANES-1:0] pend4;
  logic [2:0]           pend_cnt;

  always_comb begin
    pend4                = '0;
    pend4[N_LANES-1:0]   = pend;
    pend_cnt             = popcount4(pend4);
  end

  always_comb begin
    csr_sel = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (pend[i]) csr_sel = SEL_W'(i);
    end
  end

  assign csr_we = fire & (|pend);
  assign last   = (pend_cnt <= 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      // pend & (pend-1) drops exactly the lowest set bit, i.e. the lane just written
      if (load) begin
        pend <= load_mask;
      end else if (csr_we) begin
        pend <= pend & (pend - N_LANES'(1));
      end

      if (flush) begin
        state <= IDLE;
      end else if (fire) begin
        if (state == IDLE) begin
          if (pend_cnt >= 3'd2) state <= DRAIN;
        end else begin
          if (pend_cnt == 3'd2) state <= IDLE;
        end
      end
    end
  end

endmodule

// File: rtl/writeback_multi.sv
// rtl/writeback_multi.sv - multi-lane writeback: regfile ports, serialised CSR port, instret counter
module writeback_multi #(
  parameter int N_LANES    = 2,
  parameter int XLEN       = 32,
  parameter int REG_IDX_W  = 5,
  parameter int CSR_ADDR_W = 14
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  writeback_multi_if.slave bus
);
  import cpu_defs::*;

  localparam int SEL_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  wb_lane_t                     lane_q [N_LANES];
  logic                         gpr_done;
  logic [63:0]                  instret_q;
  logic [N_LANES-1:0]           valid;
  logic [MAX_LANES-1:0]         valid4;
  logic [2:0]                   valid_cnt;
  logic                         bvalid;
  logic                         fire;
  logic                         rdy;
  logic                         csr_we;
  logic [SEL_W-1:0]             csr_sel;
  logic                         csr_last;
  logic [N_LANES-1:0]           reg_we;
  logic [N_LANES*REG_IDX_W-1:0] reg_idx;
  logic [N_LANES*XLEN-1:0]      reg_data;
  logic [CSR_ADDR_W-1:0]        csr_addr;
  logic [XLEN-1:0]              csr_data;

  always_comb begin
    valid = '0;
    for (int i = 0; i < N_LANES; i++) valid[i] = lane_q[i].valid;
    valid4              = '0;
    valid4[N_LANES-1:0] = valid;
    valid_cnt           = popcount4(valid4);
  end

  assign bvalid = |valid;
  assign fire   = bvalid & ~flush & bus.next_rdy_in;
  assign rdy    = flush | ~bvalid | (fire & csr_last);

  wb_csr_serializer #(
    .N_LANES (N_LANES),
    .SEL_W   (SEL_W)
  ) u_csr (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (rdy),
    .fire      (fire),
    .load_mask (bus.in_valid & bus.in_wr_csr),
    .csr_we    (csr_we),
    .csr_sel   (csr_sel),
    .last      (csr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) lane_q[i] <= '0;
      gpr_done  <= 1'b0;
      instret_q <= '0;
    end else begin
      if (rdy) begin
        for (int i = 0; i < N_LANES; i++) begin
          lane_q[i].valid    <= bus.in_valid[i];
          lane_q[i].rd       <= bus.in_rd[i*REG_IDX_W +: REG_IDX_W];
          lane_q[i].wr_rd    <= bus.in_wr_rd[i];
          lane_q[i].rd_data  <= bus.in_rd_data[i*XLEN +: XLEN];
          lane_q[i].wr_csr   <= bus.in_wr_csr[i];
          lane_q[i].csr_addr <= bus.in_csr_addr[i*CSR_ADDR_W +: CSR_ADDR_W];
          lane_q[i].csr_data <= bus.in_csr_data[i*XLEN +: XLEN];
        end
        gpr_done <= 1'b0;
      end else if (fire) begin
        gpr_done <= 1'b1;
      end

      if (fire && csr_last) instret_q <= instret_q + 64'(valid_cnt);
    end
  end

  // A younger lane writing the same rd shadows every older lane in the bundle
  always_comb begin
    reg_we   = '0;
    reg_idx  = '0;
    reg_data = '0;
    for (int i = 0; i < N_LANES; i++) begin
      reg_idx[i*REG_IDX_W +: REG_IDX_W] = lane_q[i].rd;
      reg_data[i*XLEN +: XLEN]          = lane_q[i].rd_data;
      reg_we[i] = fire & ~gpr_done & lane_q[i].valid & lane_q[i].wr_rd & (lane_q[i].rd != '0);
      for (int j = i + 1; j < N_LANES; j++) begin
        if (lane_q[j].valid && lane_q[j].wr_rd && (lane_q[j].rd == lane_q[i].rd)) reg_we[i] = 1'b0;
      end
    end
  end

  always_comb begin
    csr_addr = '0;
    csr_data = '0;
    if (csr_we) begin
      csr_addr = lane_q[csr_sel].csr_addr;
      csr_data = lane_q[csr_sel].csr_data;
    end
  end

  assign bus.rdy_in   = rdy;
  assign bus.reg_we   = reg_we;
  assign bus.reg_idx  = reg_idx;
  assign bus.reg_data = reg_data;
  assign bus.csr_we   = csr_we;
  assign bus.csr_addr = csr_addr;
  assign bus.csr_data = csr_data;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_writeback_multi.sv
// tb/tb_writeback_multi.sv - vector table plus write scoreboard for writeback_multi, two lanes
module tb_writeback_multi;

  bit   clk;
  logic rst;
  logic flush;

  writeback_multi_if #(.N_LANES(2), .XLEN(32), .REG_IDX_W(5), .CSR_ADDR_W(14)) bus ();

  writeback_multi #(.N_LANES(2), .XLEN(32), .REG_IDX_W(5), .CSR_ADDR_W(14)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  rd0, rd1;
    logic [1:0]  wr_rd;
    logic [31:0] d0, d1;
    logic [1:0]  wr_csr;
    logic [13:0] ca0, ca1;
    logic [31:0] cd0, cd1;
    logic [1:0]  exp_we;
    int          exp_inc;
  } vec_t;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  idx0, idx1;
    logic [31:0] data0, data1;
  } gpr_ev_t;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
  } csr_ev_t;

  int          checks   = 0;
  int          failures = 0;
  gpr_ev_t     gpr_q[$];
  csr_ev_t     csr_q[$];
  gpr_ev_t     ge;
  csr_ev_t     ce;
  logic [63:0] exp_instret;
  vec_t        vecs[9];
  vec_t        dv;
  bit          done;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  task automatic idle_inputs();
    bus.in_valid    = '0;
    bus.in_rd       = '0;
    bus.in_wr_rd    = '0;
    bus.in_rd_data  = '0;
    bus.in_wr_csr   = '0;
    bus.in_csr_addr = '0;
    bus.in_csr_data = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid    = v.valid;
    bus.in_rd       = {v.rd1, v.rd0};
    bus.in_wr_rd    = v.wr_rd;
    bus.in_rd_data  = {v.d1, v.d0};
    bus.in_wr_csr   = v.wr_csr;
    bus.in_csr_addr = {v.ca1, v.ca0};
    bus.in_csr_data = {v.cd1, v.cd0};
  endtask

  task automatic push_exp(input vec_t v);
    if (v.exp_we != 2'b00) gpr_q.push_back('{v.exp_we, v.rd0, v.rd1, v.d0, v.d1});
    if (v.valid[0] && v.wr_csr[0]) csr_q.push_back('{v.ca0, v.cd0});
    if (v.valid[1] && v.wr_csr[1]) csr_q.push_back('{v.ca1, v.cd1});
    exp_instret = exp_instret + 64'(v.exp_inc);
  endtask

  task automatic check_drained(string tag);
    chk({tag, "_instret"}, bus.instret, exp_instret);
    chk({tag, "_gpr_left"}, 64'(gpr_q.size()), 0);
    chk({tag, "_csr_left"}, 64'(csr_q.size()), 0);
  endtask

  // Scoreboard: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (bus.reg_we != 2'b00) begin
        if (gpr_q.size() == 0) begin
          chk("unexpected_reg_we", 64'(bus.reg_we), 0);
        end else begin
          ge = gpr_q.pop_front();
          chk("reg_we", 64'(bus.reg_we), 64'(ge.we));
          if (ge.we[0]) begin
            chk("reg_idx0", 64'(bus.reg_idx[4:0]), 64'(ge.idx0));
            chk("reg_data0", 64'(bus.reg_data[31:0]), 64'(ge.data0));
          end
          if (ge.we[1]) begin
            chk("reg_idx1", 64'(bus.reg_idx[9:5]), 64'(ge.idx1));
            chk("reg_data1", 64'(bus.reg_data[63:32]), 64'(ge.data1));
          end
        end
      end
      if (bus.csr_we) begin
        if (csr_q.size() == 0) begin
          chk("unexpected_csr_we", 64'(bus.csr_we), 0);
        end else begin
          ce = csr_q.pop_front();
          chk("csr_addr", 64'(bus.csr_addr), 64'(ce.addr));
          chk("csr_data", 64'(bus.csr_data), 64'(ce.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          valid  rd0 rd1 wr_rd  d0        d1      wr_csr ca0      ca1      cd0     cd1     exp_we inc
    vecs[0] = '{2'b11, 5,  5,  2'b11, 'h11,     'h22,   2'b00, 'h0,     'h0,     'h0,    'h0,    2'b10, 2};
    vecs[1] = '{2'b11, 3,  4,  2'b11, 'haa,     'hbb,   2'b00, 'h0,     'h0,     'h0,    'h0,    2'b11, 2};
    vecs[2] = '{2'b11, 0,  7,  2'b11, 'hdead,   'h77,   2'b00, 'h0,     'h0,     'h0,    'h0,    2'b10, 2};
    vecs[3] = '{2'b01, 9,  9,  2'b11, 'h99,     'h98,   2'b00, 'h0,     'h0,     'h0,    'h0,    2'b01, 1};
    vecs[4] = '{2'b00, 1,  2,  2'b11, 'h1,      'h2,    2'b11, 'h1,     'h2,     'h3,    'h4,    2'b00, 0};
    vecs[5] = '{2'b11, 1,  2,  2'b11, 'h101,    'h102,  2'b11, 'h0,     'h5,     'hc0,   'hc5,   2'b11, 2};
    vecs[6] = '{2'b10, 0,  0,  2'b00, 'h0,      'h0,    2'b10, 'h0,     'h300,   'h0,    'h1234, 2'b00, 1};
    vecs[7] = '{2'b11, 8,  8,  2'b01, 'h81,     'h82,   2'b01, 'h3ff,   'h0,     'habc,  'h0,    2'b01, 2};
    vecs[8] = '{2'b11, 31, 31, 2'b11, 'h1,      'h2,    2'b11, 'h3fff,  'h3fff,  'h5,    'h6,    2'b10, 2};

    rst = 1'b1;
    flush = 1'b0;
    bus.next_rdy_in = 1'b1;
    idle_inputs();
    exp_instret = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_we", 64'(bus.reg_we), 0);
    chk("rst_csr_we", 64'(bus.csr_we), 0);
    chk("rst_rdy_in", 64'(bus.rdy_in), 1);
    chk("rst_instret", bus.instret, 0);
    chk("rst_reg_data", 64'(bus.reg_data), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 9; k++) begin
      drive(vecs[k]);
      bus.next_rdy_in = 1'b1;
      push_exp(vecs[k]);
      @(posedge clk);
      #1;
      idle_inputs();
      done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
        bus.next_rdy_in = ($urandom_range(0, 3) != 0);
        #1;
        if (bus.rdy_in) done = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      if (!done) chk("vec_rdy_timeout", 0, 1);
      @(posedge clk);
      #1;
      check_drained($sformatf("vec%0d", k));
    end

    // Two CSR writes separated by a three-cycle stall
    dv = '{2'b11, 1, 2, 2'b11, 'h5a, 'h5b, 2'b11, 'h0, 'h5, 'hd0, 'hd5, 2'b11, 2};
    drive(dv);
    push_exp(dv);
    bus.next_rdy_in = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("stall_c1_csr_we", 64'(bus.csr_we), 1);
    chk("stall_c1_csr_addr", 64'(bus.csr_addr), 'h0);
    chk("stall_c1_rdy_in", 64'(bus.rdy_in), 0);
    chk("stall_c1_reg_we", 64'(bus.reg_we), 'b11);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      bus.next_rdy_in = 1'b0;
      #1;
      chk("stall_hold_csr_we", 64'(bus.csr_we), 0);
      chk("stall_hold_reg_we", 64'(bus.reg_we), 0);
      chk("stall_hold_rdy_in", 64'(bus.rdy_in), 0);
    end
    @(posedge clk);
    #1;
    bus.next_rdy_in = 1'b1;
    #1;
    chk("stall_c2_csr_we", 64'(bus.csr_we), 1);
    chk("stall_c2_csr_addr", 64'(bus.csr_addr), 'h5);
    chk("stall_c2_reg_we", 64'(bus.reg_we), 0);
    chk("stall_c2_rdy_in", 64'(bus.rdy_in), 1);
    @(posedge clk);
    #1;
    chk("stall_after_csr_we", 64'(bus.csr_we), 0);
    check_drained("stall");

    // Flush (with a simultaneous stall) after the first of two CSR writes
    dv = '{2'b11, 0, 0, 2'b00, 'h0, 'h0, 2'b11, 'ha, 'hb, 'hf0, 'hf1, 2'b00, 0};
    drive(dv);
    csr_q.push_back('{14'ha, 32'hf0});
    bus.next_rdy_in = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("flush_c1_csr_we", 64'(bus.csr_we), 1);
    chk("flush_c1_csr_addr", 64'(bus.csr_addr), 'ha);
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.next_rdy_in = 1'b0;
    #1;
    chk("flush_csr_we", 64'(bus.csr_we), 0);
    chk("flush_rdy_in", 64'(bus.rdy_in), 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.next_rdy_in = 1'b1;
    #1;
    chk("flush_after_csr_we", 64'(bus.csr_we), 0);
    chk("flush_after_rdy_in", 64'(bus.rdy_in), 1);
    check_drained("flush");

    // Reset while a CSR write is still pending; a bundle offered during reset is dropped
    dv = '{2'b11, 4, 5, 2'b11, 'h44, 'h55, 2'b11, 'h10, 'h11, 'he0, 'he1, 2'b11, 2};
    drive(dv);
    gpr_q.push_back('{2'b11, 5'd4, 5'd5, 32'h44, 32'h55});
    csr_q.push_back('{14'h10, 32'he0});
    bus.next_rdy_in = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("rstmid_c1_csr_addr", 64'(bus.csr_addr), 'h10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.next_rdy_in = 1'b0;
    dv = '{2'b11, 6, 7, 2'b11, 'h66, 'h77, 2'b00, 'h0, 'h0, 'h0, 'h0, 2'b00, 0};
    drive(dv);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    bus.next_rdy_in = 1'b1;
    exp_instret = '0;
    #1;
    chk("rstmid_csr_we", 64'(bus.csr_we), 0);
    chk("rstmid_rdy_in", 64'(bus.rdy_in), 1);
    chk("rstmid_reg_we", 64'(bus.reg_we), 0);
    @(posedge clk);
    #1;
    check_drained("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
